// File: rtl/store_buffer_pkg.sv
// rtl/store_buffer_pkg.sv - shared lane count, depth default, drain FSM encoding and entry layout
package store_buffer_pkg;

    localparam int SB_LANES         = 4;
    localparam int SB_DEPTH_DEFAULT = 4;

    typedef enum logic {
        SB_IDLE = 1'b0,
        SB_REQ  = 1'b1
    } sb_state_t;

    typedef struct packed {
        logic [29:0]         addr;
        logic [31:0]         data;
        logic [SB_LANES-1:0] be;
    } sb_entry_t;

    // be bit i owns the big-endian-positioned lane data[31-8i -: 8]
    function automatic logic [31:0] sb_merge_lanes(input logic [31:0]         old_data,
                                                   input logic [31:0]         new_data,
                                                   input logic [SB_LANES-1:0] be);
        logic [31:0] r;
        r = old_data;
        for (int i = 0; i < SB_LANES; i++) begin
            if (be[i]) r[31-8*i -: 8] = new_data[31-8*i -: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/store_buffer_entry_fifo.sv
// rtl/store_buffer_entry_fifo.sv - sb_entry_fifo: circular entry storage with per-slot valid bits
module sb_entry_fifo
    import store_buffer_pkg::*;
#(
    parameter int DEPTH = SB_DEPTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  sb_entry_t        push_entry,
    input  logic             pop,
    input  logic             merge,
    input  sb_entry_t        merge_entry,
    output sb_entry_t        head,
    output sb_entry_t        tail,
    output sb_entry_t        entries [DEPTH],
    output logic [DEPTH-1:0] valid,
    output logic [3:0]       count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] tail_ptr;
    sb_entry_t     mem [DEPTH];

    assign tail_ptr = wr_ptr - 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            valid  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + {3'b000, push} - {3'b000, pop};
            // push and pop never share a slot: a push into a full buffer is refused upstream
            if (pop)  valid[rd_ptr] <= 1'b0;
            if (push) valid[wr_ptr] <= 1'b1;
        end
    end

    // payload needs no reset; valid bits alone define occupancy
    always_ff @(posedge clk) begin
        if (push)  mem[wr_ptr]   <= push_entry;
        if (merge) mem[tail_ptr] <= merge_entry;
    end

    assign entries = mem;
    assign head    = mem[rd_ptr];
    assign tail    = mem[tail_ptr];

endmodule

// File: rtl/store_buffer.sv
// rtl/store_buffer.sv - store buffer with drain FSM and load-hazard detect
// Optional store merging into the tail entry when STORE_MERGE_EN is defined.
module store_buffer
    import store_buffer_pkg::*;
#(
    parameter int DEPTH = SB_DEPTH_DEFAULT
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wr_valid,
    input  logic [31:0]         wr_addr,
    input  logic [31:0]         wr_data,
    input  logic [SB_LANES-1:0] wr_be,
    output logic                wr_ready,
    input  logic [31:0]         ld_addr,
    output logic                ld_hazard,
    output logic                mem_req,
    output logic [31:0]         mem_addr,
    output logic [31:0]         mem_wdata,
    output logic [SB_LANES-1:0] mem_be,
    input  logic                mem_ack,
    output logic                empty,
    output logic [3:0]          count
);

    sb_state_t        state, state_next;
    sb_entry_t        head, tail, new_entry, merge_entry;
    sb_entry_t        entries [DEPTH];
    logic [DEPTH-1:0] valid;
    logic             store_en, merge_hit, push, pop;
    logic             unused_bits;

    assign store_en  = wr_valid && (wr_be != '0);
    assign new_entry = '{addr: wr_addr[31:2], data: wr_data, be: wr_be};

`ifdef STORE_MERGE_EN
    // the head is frozen while its request is outstanding, so it is never a merge target
    assign merge_hit   = store_en && (count != 4'd0) && (tail.addr == wr_addr[31:2])
                         && !((count == 4'd1) && (state == SB_REQ));
    assign merge_entry = '{addr: tail.addr,
                           data: sb_merge_lanes(tail.data, wr_data, wr_be),
                           be:   tail.be | wr_be};
    assign wr_ready    = (count < 4'(DEPTH)) || merge_hit;
    assign unused_bits = &{1'b0, wr_addr[1:0], ld_addr[1:0]};
`else
    assign merge_hit   = 1'b0;
    assign merge_entry = '0;
    assign wr_ready    = (count < 4'(DEPTH));
    assign unused_bits = &{1'b0, wr_addr[1:0], ld_addr[1:0], tail};
`endif

    assign push  = store_en && wr_ready && !merge_hit;
    assign pop   = (state == SB_REQ) && mem_ack;
    assign empty = (count == 4'd0);

    sb_entry_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push        (push),
        .push_entry  (new_entry),
        .pop         (pop),
        .merge       (merge_hit),
        .merge_entry (merge_entry),
        .head        (head),
        .tail        (tail),
        .entries     (entries),
        .valid       (valid),
        .count       (count)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= SB_IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            SB_IDLE: if (count != 4'd0) state_next = SB_REQ;
            SB_REQ:  if (mem_ack && (count == 4'd1) && !push) state_next = SB_IDLE;
            default: state_next = SB_IDLE;
        endcase
    end

    always_comb begin
        mem_req   = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_be    = '0;
        if (state == SB_REQ) begin
            mem_req   = 1'b1;
            mem_addr  = {head.addr, 2'b00};
            mem_wdata = head.data;
            mem_be    = head.be;
        end
    end

    always_comb begin
        ld_hazard = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid[i] && (entries[i].addr == ld_addr[31:2])) ld_hazard = 1'b1;
        end
    end

endmodule

// File: doc/store_buffer.md
STORE_BUFFER -- requirements
Module: store_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning number of buffered store entries (power of two, 2..8).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port wr_valid  input  1  store presented by MEM stage this cycle.
REQ-005 SHALL have port wr_addr  input  32  store byte address; bits [1:0] ignored (word-granular).
REQ-006 SHALL have port wr_data  input  32  lane-positioned store data from write-data encoder.
REQ-007 SHALL have port wr_be  input  4  byte enables; bit i selects byte wr_data[31-8i -: 8].
REQ-008 SHALL have port wr_ready  output  1  buffer can accept the presented store.
REQ-009 SHALL have port ld_addr  input  32  address of load in MEM stage.
REQ-010 SHALL have port ld_hazard  output  1  pending store to ld_addr word exists.
REQ-011 SHALL have ports mem_req out 1, mem_addr out 32, mem_wdata out 32, mem_be out 4, mem_ack in 1: data-memory write channel.
REQ-012 SHALL have ports empty out 1 and count out 4: occupancy status.

Function
REQ-013 SHALL push an entry {wr_addr[31:2], wr_data, wr_be} at an edge where wr_valid=1, wr_be!=0, wr_ready=1.
REQ-014 SHALL ignore wr_valid=1 with wr_be=0 (no push, no count change).
REQ-015 SHALL drive wr_ready = (count < DEPTH) (merge exception in REQ-030).
REQ-016 SHALL run drain FSM states IDLE, REQ: IDLE->REQ when count!=0; REQ holds until mem_ack=1; on ack pop head, go IDLE if count becomes 0, else stay REQ with next head.
REQ-017 SHALL drive mem_req=1 exactly in REQ; mem_addr={head addr,2'b00}, mem_wdata, mem_be from head, held stable until ack; all zero in IDLE.
REQ-018 SHALL give latency: push at edge E0 into empty buffer -> mem_req high after edge E1.
REQ-019 SHALL, on simultaneous push and ack-pop, leave count unchanged and preserve FIFO order.
REQ-020 SHALL ignore mem_ack while in IDLE.
REQ-021 SHALL drive ld_hazard combinationally: 1 iff any valid entry (including head in flight) has addr == ld_addr[31:2].
REQ-022 SHALL wrap read/write pointers modulo DEPTH; count in 0..DEPTH; empty = (count==0).
REQ-023 SHALL never write memory bytes whose mem_be bit is 0.

Reset
REQ-024 SHALL, on rst=1, immediately set count=0, pointers=0, FSM=IDLE, mem_req=0, mem_addr/mem_wdata/mem_be=0, empty=1, ld_hazard=0.
REQ-025 SHALL discard all buffered entries, including in-flight request, on reset mid-operation; no retry after release.
REQ-026 SHALL accept a push on the first edge after rst deasserts.

Configuration
REQ-027 SHALL compile store merging only when macro STORE_MERGE_EN is defined.
REQ-028 SHALL, with STORE_MERGE_EN: merge a store hitting the tail entry's address into that entry instead of pushing, unless tail is the head in REQ.
REQ-029 SHALL, on merge, overwrite only bytes selected by wr_be and set tail be = old be | wr_be; count unchanged.
REQ-030 SHALL, with STORE_MERGE_EN, drive wr_ready = (count<DEPTH) | merge_hit.
REQ-031 SHALL, without STORE_MERGE_EN, always push a new entry; no merge logic present.

Structure
REQ-032 SHALL take byte-lane count, DEPTH default and FSM state encodings from the shared cpu package.
REQ-033 SHALL isolate entry storage and pointers in sub-module sb_entry_fifo; FSM, hazard compare and merge stay in store_buffer.

Verification
REQ-034 SHALL verify: push addr 0x100, data 0xAABBCCDD, be 4'b1111 -> mem_req after E1, mem_addr 0x100; ack after 3 cycles -> empty=1.
REQ-035 SHALL verify: 5 pushes with mem_ack=0, DEPTH=4 -> wr_ready=0 after 4th, count=4; 5th held until first ack.
REQ-036 SHALL verify: pending store 0x204, ld_addr 0x206 -> ld_hazard=1; ld_addr 0x208 -> 0.
REQ-037 SHALL verify: push+ack same edge at count=2 -> count stays 2, drain order preserved.
REQ-038 SHALL verify (STORE_MERGE_EN): be 0001 data 0x11000000 then be 0100 data 0x00002200 to 0x300 behind busy head -> one entry be 0101 data 0x11002200.
REQ-039 SHALL verify: rst asserted during REQ with 3 entries -> mem_req=0, count=0 same cycle.
